// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared memory
// and a single ALU, with a ready handshake on memory and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opCode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUop,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] DECODE = 4'd2;
  localparam logic [3:0] MEMADR = 4'd3;
  localparam logic [3:0] MEMRD  = 4'd4;
  localparam logic [3:0] MEMWB  = 4'd5;
  localparam logic [3:0] MEMWR  = 4'd6;
  localparam logic [3:0] EXEC   = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;
  localparam logic [3:0] JUMP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] stateReg;
  logic [3:0] stateNext;
  logic       retire;
  logic       legalOp;

  // The branch condition is applied in the datapath (PCWriteCond & zero), not here.
  logic unusedZero;
  assign unusedZero = zero;

  always_comb begin
    legalOp = 1'b0;
    case (opCode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legalOp = 1'b1;
      default:                                       legalOp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      instr_count <= '0;
    end else begin
      stateReg <= stateNext;
      if (retire) instr_count <= instr_count + COUNT_W'(1);
    end
  end

  always_comb begin
    stateNext = stateReg;
    retire    = 1'b0;
    case (stateReg)
      IDLE:   stateNext = FETCH;
      FETCH:  if (mem_ready) stateNext = DECODE;
      DECODE: begin
        case (opCode)
          OP_RTYPE:      stateNext = EXEC;
          OP_LW, OP_SW:  stateNext = MEMADR;
          OP_BEQ:        stateNext = BRANCH;
          OP_ADDI:       stateNext = ADDIEX;
          OP_J:          stateNext = JUMP;
          default:       stateNext = FETCH;
        endcase
      end
      MEMADR: stateNext = (opCode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) stateNext = MEMWB;
      MEMWR: begin
        if (mem_ready) begin
          stateNext = FETCH;
          retire    = 1'b1;
        end
      end
      EXEC:   stateNext = ALUWB;
      ADDIEX: stateNext = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
        stateNext = FETCH;
        retire    = 1'b1;
      end
      default: stateNext = FETCH;
    endcase
  end

  // Outputs decode from the state register, so an async reset clears them at once.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 3'b000;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    case (stateReg)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !legalOp;
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 3'b010;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a vector table walks every instruction class,
// followed by hand sequences for async reset mid-store and counter wrap.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opCode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUop;
  logic [3:0] instr_count;

  multicycle_ctrl #(.COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [17:0] actOut;
  assign actOut = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal_op};

  localparam logic [17:0] PCW     = 18'd1 << 17;
  localparam logic [17:0] PCWC    = 18'd1 << 16;
  localparam logic [17:0] IORD    = 18'd1 << 15;
  localparam logic [17:0] MRD     = 18'd1 << 14;
  localparam logic [17:0] MWR     = 18'd1 << 13;
  localparam logic [17:0] IRW     = 18'd1 << 12;
  localparam logic [17:0] M2R     = 18'd1 << 11;
  localparam logic [17:0] RDST    = 18'd1 << 10;
  localparam logic [17:0] RW      = 18'd1 << 9;
  localparam logic [17:0] SRCA    = 18'd1 << 8;
  localparam logic [17:0] SRCB_4  = 18'd1 << 6;
  localparam logic [17:0] SRCB_SE = 18'd2 << 6;
  localparam logic [17:0] SRCB_SH = 18'd3 << 6;
  localparam logic [17:0] AOP_SUB = 18'd1 << 3;
  localparam logic [17:0] AOP_FN  = 18'd2 << 3;
  localparam logic [17:0] PCS_OUT = 18'd1 << 1;
  localparam logic [17:0] PCS_J   = 18'd2 << 1;
  localparam logic [17:0] ILL     = 18'd1;

  localparam logic [17:0] O_IDLE   = 18'd0;
  localparam logic [17:0] O_FETCHW = MRD | SRCB_4;
  localparam logic [17:0] O_FETCHR = MRD | SRCB_4 | IRW | PCW;
  localparam logic [17:0] O_DEC    = SRCB_SH;
  localparam logic [17:0] O_DECILL = SRCB_SH | ILL;
  localparam logic [17:0] O_ADR    = SRCA | SRCB_SE;
  localparam logic [17:0] O_MEMRD  = MRD | IORD;
  localparam logic [17:0] O_MEMWB  = RW | M2R;
  localparam logic [17:0] O_MEMWR  = MWR | IORD;
  localparam logic [17:0] O_EXEC   = SRCA | AOP_FN;
  localparam logic [17:0] O_ALUWB  = RW | RDST;
  localparam logic [17:0] O_BR     = SRCA | AOP_SUB | PCWC | PCS_OUT;
  localparam logic [17:0] O_ADDIWB = RW;
  localparam logic [17:0] O_JMP    = PCW | PCS_J;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [17:0] expOut;
    logic [3:0]  expCnt;
  } vec_t;

  vec_t vq[$];
  int nCompared = 0;
  int nMismatch = 0;

  function automatic vec_t mkVec(string tag, logic [5:0] op, logic z, logic rdy,
                                 logic [17:0] expOut, logic [3:0] expCnt);
    vec_t v;
    v.tag = tag; v.op = op; v.z = z; v.rdy = rdy; v.expOut = expOut; v.expCnt = expCnt;
    return v;
  endfunction

  task automatic checkDut(input string tag, input logic [17:0] expOut, input logic [3:0] expCnt);
    nCompared += 3;
    $display("%-12s op=%b rdy=%b z=%b out=%h cnt=%0d", tag, opCode, mem_ready, zero, actOut, instr_count);
    if (actOut !== expOut) begin
      nMismatch++;
      $display("FAIL %s outputs: got %h required %h", tag, actOut, expOut);
    end
    if (instr_count !== expCnt) begin
      nMismatch++;
      $display("FAIL %s instr_count: got %0d required %0d", tag, instr_count, expCnt);
    end
    if ((MemRead & MemWrite) !== 1'b0) begin
      nMismatch++;
      $display("FAIL %s rd_wr_excl: got MemRead=%b MemWrite=%b required not both", tag, MemRead, MemWrite);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic z, input logic rdy,
                      input logic [17:0] expOut, input logic [3:0] expCnt);
    @(negedge clk);
    opCode = op; zero = z; mem_ready = rdy;
    #1;
    checkDut(tag, expOut, expCnt);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkDut("reset", O_IDLE, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // R-type, then lw with three wait cycles in MEMRD
    vq.push_back(mkVec("idle",      RT,   0, 1, O_IDLE,   0));
    vq.push_back(mkVec("r_fetch",   RT,   0, 1, O_FETCHR, 0));
    vq.push_back(mkVec("r_decode",  RT,   0, 1, O_DEC,    0));
    vq.push_back(mkVec("r_exec",    RT,   0, 1, O_EXEC,   0));
    vq.push_back(mkVec("r_aluwb",   RT,   0, 1, O_ALUWB,  0));
    vq.push_back(mkVec("lw_fwait",  LW,   0, 0, O_FETCHW, 1));
    vq.push_back(mkVec("lw_fetch",  LW,   0, 1, O_FETCHR, 1));
    vq.push_back(mkVec("lw_decode", LW,   0, 1, O_DEC,    1));
    vq.push_back(mkVec("lw_memadr", LW,   0, 1, O_ADR,    1));
    vq.push_back(mkVec("lw_wait1",  LW,   0, 0, O_MEMRD,  1));
    vq.push_back(mkVec("lw_wait2",  LW,   0, 0, O_MEMRD,  1));
    vq.push_back(mkVec("lw_wait3",  LW,   0, 0, O_MEMRD,  1));
    vq.push_back(mkVec("lw_memrd",  LW,   0, 1, O_MEMRD,  1));
    vq.push_back(mkVec("lw_memwb",  LW,   0, 1, O_MEMWB,  1));
    // beq taken then not taken: identical control both times
    vq.push_back(mkVec("beq1_fetch", BEQ, 1, 1, O_FETCHR, 2));
    vq.push_back(mkVec("beq1_dec",   BEQ, 1, 1, O_DEC,    2));
    vq.push_back(mkVec("beq1_br",    BEQ, 1, 1, O_BR,     2));
    vq.push_back(mkVec("beq0_fetch", BEQ, 0, 1, O_FETCHR, 3));
    vq.push_back(mkVec("beq0_dec",   BEQ, 0, 1, O_DEC,    3));
    vq.push_back(mkVec("beq0_br",    BEQ, 0, 1, O_BR,     3));
    vq.push_back(mkVec("ill_fetch",  BAD, 0, 1, O_FETCHR, 4));
    vq.push_back(mkVec("ill_dec",    BAD, 0, 1, O_DECILL, 4));
    vq.push_back(mkVec("addi_fetch", ADDI, 0, 1, O_FETCHR, 4));
    vq.push_back(mkVec("addi_dec",   ADDI, 0, 1, O_DEC,    4));
    vq.push_back(mkVec("addi_ex",    ADDI, 0, 1, O_ADR,    4));
    vq.push_back(mkVec("addi_wb",    ADDI, 0, 1, O_ADDIWB, 4));
    vq.push_back(mkVec("sw_fetch",   SW,  0, 1, O_FETCHR, 5));
    vq.push_back(mkVec("sw_dec",     SW,  0, 1, O_DEC,    5));
    vq.push_back(mkVec("sw_memadr",  SW,  0, 1, O_ADR,    5));
    vq.push_back(mkVec("sw_wait",    SW,  0, 0, O_MEMWR,  5));
    vq.push_back(mkVec("sw_memwr",   SW,  0, 1, O_MEMWR,  5));
    vq.push_back(mkVec("j_fetch",    JMP, 0, 1, O_FETCHR, 6));
    vq.push_back(mkVec("j_dec",      JMP, 0, 1, O_DEC,    6));
    vq.push_back(mkVec("j_jump",     JMP, 0, 1, O_JMP,    6));
    vq.push_back(mkVec("end_fetch",  JMP, 0, 0, O_FETCHW, 7));

    repeat (2) @(negedge clk);
    #1;
    checkDut("reset", O_IDLE, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++)
      step(vq[i].tag, vq[i].op, vq[i].z, vq[i].rdy, vq[i].expOut, vq[i].expCnt);

    // Asynchronous reset in the middle of a stalled store
    resetDut();
    step("a_idle",    JMP, 0, 1, O_IDLE,   0);
    step("a_jfetch",  JMP, 0, 1, O_FETCHR, 0);
    step("a_jdec",    JMP, 0, 1, O_DEC,    0);
    step("a_jump",    JMP, 0, 1, O_JMP,    0);
    step("a_swfetch", SW,  0, 1, O_FETCHR, 1);
    step("a_swdec",   SW,  0, 1, O_DEC,    1);
    step("a_swadr",   SW,  0, 1, O_ADR,    1);
    step("a_swwait",  SW,  0, 0, O_MEMWR,  1);
    #2 rst_n = 1'b0;
    #1;
    checkDut("a_rstmid", O_IDLE, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("a_idle2",   SW,  0, 1, O_IDLE,   0);
    step("a_fetch2",  SW,  0, 0, O_FETCHW, 0);

    // Sixteen jumps wrap the 4-bit counter back to zero
    resetDut();
    step("w_idle", JMP, 0, 1, O_IDLE, 0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("w%0d_fetch", i), JMP, 0, 1, O_FETCHR, 4'(i));
      step($sformatf("w%0d_dec", i),   JMP, 0, 1, O_DEC,    4'(i));
      step($sformatf("w%0d_jump", i),  JMP, 0, 1, O_JMP,    4'(i));
    end
    step("w_wrapped", JMP, 0, 0, O_FETCHW, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the MIPS datapath as a multi-cycle machine: shared memory for instruction and data, one ALU reused for PC increment, address and branch-target computation.
- Replaces the single-cycle opcode decoder.
- Sits beside the datapath and drives every mux select and enable from the latched instruction opcode.
- Supports variable-latency memory through a ready handshake, and counts retired instructions.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opCode  input  6  instruction[31:26] from instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if zero=1.
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  write-back source: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  0 = rt, 1 = rd.
- RegWrite  output  1  register bank write enable.
- ALUSrcA  output  1  0 = PC, 1 = reg A.
- ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = signExt, 11 = signExt<<2.
- ALUop  output  3  000 add, 001 sub, 010 use func field.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  one-cycle pulse on unsupported opcode.
- instr_count  output  COUNT_W  retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, instr_count=0.
  - All outputs 0 while in IDLE. Reset mid-instruction aborts immediately; no partial write may occur after rst_n falls.
- States and transitions:
  - IDLE -> FETCH unconditionally, first clk after reset release.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSource=00. Stays while mem_ready=0. IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1 (Mealy), then -> DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=000 (branch target into ALUOut). Next state by opCode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - any other: illegal_op=1 for this cycle, -> FETCH, not counted.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=000. -> MEMRD (lw) or MEMWR (sw).
  - MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then -> MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
  - MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then -> FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=010. -> ALUWB.
  - ALUWB: RegWrite=1, MemtoReg=0, RegDst=1. -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=001, PCWriteCond=1, PCSource=01. -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=000. -> ADDIWB.
  - ADDIWB: RegWrite=1, MemtoReg=0, RegDst=0. -> FETCH.
  - JUMP: PCWrite=1, PCSource=10. -> FETCH.
- Signal defaults: every output not listed for a state is 0. MemRead and MemWrite are never both 1.
- Handshake: MemRead/MemWrite and IorD are held stable while waiting. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Latency with mem_ready tied 1:
  - lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- instr_count: +1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. Wraps modulo 2^COUNT_W. IDLE->FETCH and illegal->FETCH do not count.
- State encoding: implementer's choice. An unreachable state code returns to FETCH on the next clk.

Test Plan:
- Reset then mem_ready=1, opCode=000000 -> states IDLE, FETCH, DECODE, EXEC, ALUWB. RegWrite=1 with RegDst=1 in ALUWB only. instr_count=1 after 5 cycles.
- lw (100011) with mem_ready low 3 cycles in MEMRD -> MemRead=1 and IorD=1 held 4 cycles. MEMWB asserts RegWrite=1 and MemtoReg=1. Total 8 cycles from FETCH.
- beq (000100) with zero=1, then zero=0 -> PCWriteCond=1, PCSource=01, ALUop=001 in BRANCH both times; 3 cycles each; instr_count increments by 2.
- opCode=111111 -> illegal_op pulses exactly 1 cycle in DECODE. Returns to FETCH; instr_count unchanged; no RegWrite or MemWrite asserted.
- sw (101011), rst_n dropped asynchronously mid-MEMWR -> MemWrite=0 immediately and all outputs 0. After release: IDLE then FETCH, instr_count=0.
- Preload instr_count to 2^COUNT_W-1 (COUNT_W=4: 15 jumps, then one more) -> count wraps to 0. JUMP asserts PCWrite=1 and PCSource=10.
